// File: rtl/expansion_shiftreg_scheduler.sv
// Frame sequencer for a 74HC165 / 74HC595 serial expansion chain.
// Each frame parallel-loads the input chain, shifts WIDTH bits MSB first,
// latches the output chain and publishes the sampled input image.
// Frames start on request or from an internal refresh timer.
module expansion_shiftreg_scheduler #(
  parameter int WIDTH   = 32,
  parameter int DIVIDER = 100,
  parameter int REFRESH = 10000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             auto_en,
  input  logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             frame_done,
  output logic             SHIFT_CLK,
  output logic             SHIFT_OUT,
  input  logic             SHIFT_IN,
  output logic             SHIFT_LOAD,
  output logic             SHIFT_LATCH
);

  localparam int PW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam int RW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
  localparam logic [PW-1:0] PHASE_LAST   = PW'(DIVIDER - 1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'((REFRESH > 0) ? REFRESH - 1 : 0);
  localparam logic [7:0]    BIT_LAST     = 8'(WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LATCH
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic [7:0]       bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] data_in_q, data_in_d;
  logic             pending_q, pending_d;
  logic [RW-1:0]    refresh_q, refresh_d;

  logic phase_end;
  logic refresh_hit;
  logic trigger;

  // Phase end and trigger decode shared by the FSM and the datapath.
  always_comb begin
    phase_end = (phase_q == PHASE_LAST);
    trigger   = (state_q == ST_IDLE) && (start || pending_q || refresh_hit);
  end

  // Refresh timer: free-runs while enabled, wraps on its last count and flags expiry.
  always_comb begin
    refresh_d   = '0;
    refresh_hit = 1'b0;
    if (auto_en && (REFRESH != 0)) begin
      if (refresh_q == REFRESH_LAST) begin
        refresh_hit = 1'b1;
      end else begin
        refresh_d = refresh_q + 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: every active phase lasts exactly DIVIDER clocks.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (trigger) state_d = ST_LOAD;
      ST_LOAD:     if (phase_end) state_d = ST_SHIFT_LO;
      ST_SHIFT_LO: if (phase_end) state_d = ST_SHIFT_HI;
      ST_SHIFT_HI: begin
        if (phase_end) begin
          state_d = (bit_cnt_q == BIT_LAST) ? ST_LATCH : ST_SHIFT_LO;
        end
      end
      ST_LATCH:    if (phase_end) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: shadow capture, serial sampling, counters and request flag.
  always_comb begin
    phase_d   = (state_q == ST_IDLE || phase_end) ? '0 : phase_q + 1'b1;
    tx_d      = tx_q;
    rx_d      = rx_q;
    bit_cnt_d = bit_cnt_q;
    data_in_d = data_in_q;
    pending_d = pending_q;

    if (trigger) begin
      pending_d = 1'b0;
    end else if (start || refresh_hit) begin
      pending_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          tx_d      = data_out;
          bit_cnt_d = 8'd0;
        end
      end
      ST_SHIFT_LO: begin
        if (phase_end) begin
          for (int i = 0; i < WIDTH; i++) begin
            if (i == WIDTH - 1 - int'(bit_cnt_q)) rx_d[i] = SHIFT_IN;
          end
        end
      end
      ST_SHIFT_HI: begin
        if (phase_end) begin
          tx_d      = tx_q << 1;
          bit_cnt_d = bit_cnt_q + 8'd1;
        end
      end
      ST_LATCH: begin
        if (phase_end) data_in_d = rx_q;
      end
      default: ;
    endcase
  end

  // Datapath registers, all cleared by reset including mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      data_in_q <= '0;
      pending_q <= 1'b0;
      refresh_q <= '0;
    end else begin
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      data_in_q <= data_in_d;
      pending_q <= pending_d;
      refresh_q <= refresh_d;
    end
  end

  // Output decode from the current state; IDLE values double as reset values.
  always_comb begin
    busy        = 1'b0;
    frame_done  = 1'b0;
    SHIFT_CLK   = 1'b0;
    SHIFT_OUT   = 1'b0;
    SHIFT_LOAD  = 1'b1;
    SHIFT_LATCH = 1'b0;
    data_in     = data_in_q;
    case (state_q)
      ST_LOAD: begin
        busy       = 1'b1;
        SHIFT_LOAD = 1'b0;
        SHIFT_OUT  = tx_q[WIDTH-1];
      end
      ST_SHIFT_LO: begin
        busy      = 1'b1;
        SHIFT_OUT = tx_q[WIDTH-1];
      end
      ST_SHIFT_HI: begin
        busy      = 1'b1;
        SHIFT_CLK = 1'b1;
        SHIFT_OUT = tx_q[WIDTH-1];
      end
      ST_LATCH: begin
        busy        = 1'b1;
        SHIFT_LATCH = 1'b1;
        frame_done  = phase_end;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_expansion_shiftreg_scheduler.sv
// Self-checking bench for expansion_shiftreg_scheduler (WIDTH=8, DIVIDER=2, REFRESH=100).
module tb_expansion_shiftreg_scheduler;

  localparam int WIDTH   = 8;
  localparam int DIVIDER = 2;
  localparam int REFRESH = 100;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             auto_en;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             frame_done;
  logic             shift_clk;
  logic             shift_out;
  logic             shift_in;
  logic             shift_load;
  logic             shift_latch;

  logic       use_model;
  logic [7:0] pattern;
  logic [7:0] sr165;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] data_out;
    logic       use_model;
    logic [7:0] pattern;
    logic       mid;
    logic [7:0] exp_rx;
  } vec_t;

  typedef struct {
    logic [7:0] rx;
    logic [7:0] tx;
  } sb_t;

  vec_t vecs[10];
  sb_t  sbq[$];

  expansion_shiftreg_scheduler #(
    .WIDTH  (WIDTH),
    .DIVIDER(DIVIDER),
    .REFRESH(REFRESH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .auto_en    (auto_en),
    .data_out   (data_out),
    .data_in    (data_in),
    .busy       (busy),
    .frame_done (frame_done),
    .SHIFT_CLK  (shift_clk),
    .SHIFT_OUT  (shift_out),
    .SHIFT_IN   (shift_in),
    .SHIFT_LOAD (shift_load),
    .SHIFT_LATCH(shift_latch)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // 74HC165 model: parallel load while PL_n low, shift on rising serial clock.
  always @(posedge shift_clk or negedge shift_load) begin
    if (!shift_load) sr165 <= pattern;
    else             sr165 <= {sr165[6:0], 1'b0};
  end

  assign shift_in = use_model ? sr165[7] : shift_out;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic um, input logic [7:0] pat,
                               output int t);
    @(posedge clk);
    #1;
    data_out  = d;
    use_model = um;
    pattern   = pat;
    start     = 1'b1;
    t         = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitFrame(input int max_cycles);
    bit seen = 0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (frame_done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) checkOutput("frame_timeout", 0, 1);
  endtask

  // Scoreboard monitor: collects serial output bits and compares each completed frame.
  logic [7:0] tx_seen = '0;
  logic       prev_sclk = 1'b0;
  sb_t        exp_e;
  always begin
    @(negedge clk);
    if (shift_clk && !prev_sclk) tx_seen = {tx_seen[6:0], shift_out};
    prev_sclk = shift_clk;
    if (frame_done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_frame: got frame_done expected none");
      end else begin
        exp_e = sbq.pop_front();
        checkOutput("serial_out", 32'(tx_seen), 32'(exp_e.tx));
        @(posedge clk);
        #1;
        checkOutput("data_in", 32'(data_in), 32'(exp_e.rx));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t, a;
    int busy_first, busy_last, fd_first, fd_cnt, load_lo, load_first;
    int sclk_hi, sclk_pulses, last_sclk_hi, latch_cnt, first_latch;
    int fd[4], br[4], n_fd, n_br, n_busy;
    logic prev_b, prev_c, found;

    vecs[0] = '{8'hA5, 1'b0, 8'h00, 1'b0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 8'h00, 1'b0, 8'h3C};
    vecs[2] = '{8'hFF, 1'b0, 8'h00, 1'b0, 8'hFF};
    vecs[3] = '{8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[4] = '{8'h80, 1'b0, 8'h00, 1'b0, 8'h80};
    vecs[5] = '{8'h01, 1'b0, 8'h00, 1'b0, 8'h01};
    vecs[6] = '{8'h5A, 1'b1, 8'hC3, 1'b1, 8'hC3};
    vecs[7] = '{8'h96, 1'b0, 8'h00, 1'b1, 8'h96};
    vecs[8] = '{8'h0F, 1'b1, 8'hC3, 1'b0, 8'hC3};
    vecs[9] = '{8'hF0, 1'b1, 8'h81, 1'b0, 8'h81};

    rst_n = 1'b0; start = 1'b0; auto_en = 1'b0; data_out = '0;
    use_model = 1'b0; pattern = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_load", 32'(shift_load), 1);
    checkOutput("rst_pins", {29'd0, shift_clk, shift_out, shift_latch}, 0);
    checkOutput("rst_data_in", 32'(data_in), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Timing and pin sequence of one loopback frame.
    sbq.push_back('{8'hA5, 8'hA5});
    applyStimulus(8'hA5, 1'b0, 8'h00, t);
    busy_first = -1; busy_last = -1; fd_first = -1; fd_cnt = 0;
    load_lo = 0; load_first = -1; sclk_hi = 0; sclk_pulses = 0; last_sclk_hi = -1;
    latch_cnt = 0; first_latch = -1; prev_c = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy) begin
        if (busy_first < 0) busy_first = cyc;
        busy_last = cyc;
      end
      if (frame_done) begin
        if (fd_first < 0) fd_first = cyc;
        fd_cnt++;
        checkOutput("data_in_hold_at_done", 32'(data_in), 0);
      end
      if (!shift_load) begin
        if (load_first < 0) load_first = cyc;
        load_lo++;
      end
      if (shift_clk) begin
        sclk_hi++;
        last_sclk_hi = cyc;
        if (!prev_c) sclk_pulses++;
      end
      prev_c = shift_clk;
      if (shift_latch) begin
        if (first_latch < 0) first_latch = cyc;
        latch_cnt++;
      end
    end
    checkOutput("busy_first", busy_first, t + 1);
    checkOutput("busy_last", busy_last, t + 36);
    checkOutput("frame_done_cycle", fd_first, t + 36);
    checkOutput("frame_done_count", fd_cnt, 1);
    checkOutput("load_first", load_first, t + 1);
    checkOutput("load_low_cycles", load_lo, 2);
    checkOutput("sclk_pulses", sclk_pulses, 8);
    checkOutput("sclk_high_cycles", sclk_hi, 16);
    checkOutput("latch_cycles", latch_cnt, 2);
    checkOutput("latch_after_last_clk", first_latch, last_sclk_hi + 1);

    // Table-driven frames, including mid-frame data_out changes and the 165 model.
    foreach (vecs[k]) begin
      sbq.push_back('{vecs[k].exp_rx, vecs[k].data_out});
      applyStimulus(vecs[k].data_out, vecs[k].use_model, vecs[k].pattern, t);
      if (vecs[k].mid) begin
        repeat (10) @(posedge clk);
        #1;
        data_out = ~vecs[k].data_out;
      end
      waitFrame(60);
      @(posedge clk);
      #2;
      repeat (2) @(posedge clk);
    end
    use_model = 1'b0;

    // start held high: back-to-back frames with one IDLE clock between them.
    data_out = 8'h6B;
    repeat (3) sbq.push_back('{8'h6B, 8'h6B});
    @(posedge clk);
    #1;
    start = 1'b1;
    n_fd = 0; n_br = 0; prev_b = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy && !prev_b) begin
        if (n_br < 4) br[n_br] = cyc;
        n_br++;
        if (n_br == 3) start = 1'b0;
      end
      prev_b = busy;
      if (frame_done) begin
        if (n_fd < 4) fd[n_fd] = cyc;
        n_fd++;
      end
    end
    checkOutput("b2b_frames", n_fd, 3);
    checkOutput("b2b_starts", n_br, 3);
    checkOutput("b2b_gap1", br[1], fd[0] + 2);
    checkOutput("b2b_gap2", br[2], fd[1] + 2);
    start = 1'b0;

    // Refresh timer: start coincident with first expiry gives one frame; period 100.
    data_out = 8'h4D;
    repeat (3) sbq.push_back('{8'h4D, 8'h4D});
    @(posedge clk);
    #1;
    auto_en = 1'b1;
    a = cyc;
    repeat (99) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_br = 0; prev_b = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy && !prev_b) begin
        if (n_br < 4) br[n_br] = cyc;
        n_br++;
        if (n_br == 3) auto_en = 1'b0;
      end
      prev_b = busy;
    end
    checkOutput("refresh_frames", n_br, 3);
    checkOutput("refresh_rise0", br[0], a + 100);
    checkOutput("refresh_rise1", br[1], a + 200);
    checkOutput("refresh_rise2", br[2], a + 300);

    // Reset asserted during SHIFT_HI: immediate reset values and no frame afterwards.
    applyStimulus(8'h77, 1'b0, 8'h00, t);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (shift_clk) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("reach_shift_hi", 32'(found), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(busy), 0);
    checkOutput("midrst_load", 32'(shift_load), 1);
    checkOutput("midrst_pins", {28'd0, shift_clk, shift_out, shift_latch, frame_done}, 0);
    checkOutput("midrst_data_in", 32'(data_in), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_busy = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy) n_busy++;
    end
    checkOutput("post_rst_idle", n_busy, 0);
    checkOutput("post_rst_data_in", 32'(data_in), 0);
    checkOutput("scoreboard_empty", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
